// File: rtl/gnr_node_lut.sv
// Generic Boolean-network gene node: loadable truth table driving NUM_CH independent state lanes.
// Latency: state/changed/flip_cnt are registered, valid 1 cycle after the start edge.
// No backpressure: start is a strobe; lanes with a pending countdown skip starts until it expires.
module gnr_node_lut #(
  parameter int NUM_IN = 4,
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reset_nos,
  input  logic [NUM_CH-1:0]         init_state,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH*NUM_IN-1:0]  in_bits,
  input  logic [NUM_CH*DIV_W-1:0]   div,
  input  logic                      cfg_we,
  input  logic [(2**NUM_IN)-1:0]    cfg_data,
  output logic [NUM_CH-1:0]         state,
  output logic [NUM_CH-1:0]         changed,
  output logic [NUM_CH*CNT_W-1:0]   flip_cnt
);

  localparam int TBL_W = 2**NUM_IN;

  logic [TBL_W-1:0]  lut_q;
  logic [NUM_CH-1:0] state_q;
  logic [NUM_CH-1:0] changed_q;
  logic [DIV_W-1:0]  phase_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] nxt;

  // Per-lane truth-table lookup; reads the currently held table, so a same-cycle write is not seen.
  always_comb begin
    nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nxt[c] = lut_q[in_bits[c*NUM_IN +: NUM_IN]];
    end
  end

  // Truth-table storage: only rst clears it, reset_nos keeps the loaded function.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_q <= '0;
    end else if (cfg_we) begin
      lut_q <= cfg_data;
    end
  end

  // Lane state, update divider countdown, change pulse and saturating flip counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '0;
      changed_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        phase_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (reset_nos) begin
          state_q[c]   <= init_state[c];
          phase_q[c]   <= '0;
          changed_q[c] <= 1'b0;
          cnt_q[c]     <= '0;
        end else if (start[c]) begin
          if (phase_q[c] == '0) begin
            // Countdown expired: take the table value and reload the period sampled now.
            state_q[c]   <= nxt[c];
            phase_q[c]   <= div[c*DIV_W +: DIV_W];
            changed_q[c] <= (nxt[c] != state_q[c]);
            if ((nxt[c] != state_q[c]) && (cnt_q[c] != {CNT_W{1'b1}})) begin
              cnt_q[c] <= cnt_q[c] + CNT_W'(1);
            end
          end else begin
            phase_q[c]   <= phase_q[c] - DIV_W'(1);
            changed_q[c] <= 1'b0;
          end
        end else begin
          changed_q[c] <= 1'b0;
        end
      end
    end
  end

  assign state   = state_q;
  assign changed = changed_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign flip_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule
